// File: rtl/mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl
//
// Sits between the multicycle CPU core and the unified memory. For each CPU
// request it decides legality, generates per-access byte enables, replicates
// store data across byte lanes, inserts WAIT_CYCLES memory wait states,
// extracts and sign/zero-extends load data, and returns a one-cycle ready.
//
// Parameters
//   ADDR_W      byte address width (>= 3)
//   WAIT_CYCLES extra memory latency cycles per access (0..15)
//
// Ports
//   clk        system clock, all state on the rising edge
//   rst        asynchronous reset, active low
//   cpu_req    access request, sampled only in IDLE
//   cpu_we     1 = store, 0 = load
//   cpu_size   00 byte, 01 half, 10 word, 11 illegal
//   cpu_sign   load extension: 1 sign-extend, 0 zero-extend
//   cpu_addr   byte address
//   cpu_wdata  store data, right-aligned
//   cpu_rdata  extended load result (updates only on legal loads)
//   cpu_ready  one-cycle completion pulse
//   cpu_err    misaligned/illegal flag, valid with cpu_ready
//   mem_addr   word-aligned memory address
//   mem_wdata  lane-replicated store data
//   mem_we     memory write strobe (one cycle per store)
//   mem_be     byte enables, bit i covers bits 8i+7:8i
//   mem_rdata  memory read data
// ---------------------------------------------------------------------------
module mem_access_ctrl #(
    parameter int ADDR_W      = 32,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [1:0]        cpu_size,
    input  logic              cpu_sign,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_ready,
    output logic              cpu_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    input  logic [31:0]       mem_rdata
);

    localparam logic [3:0] WAIT_L = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t              state_q;
    logic [3:0]          cnt_q;
    logic                we_q;
    logic [1:0]          size_q;
    logic                sign_q;
    logic [1:0]          lane_q;
    logic [31:0]         cpu_rdata_q;
    logic                cpu_ready_q;
    logic                cpu_err_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [31:0]         mem_wdata_q;
    logic                mem_we_q;
    logic [3:0]          mem_be_q;

    // Request decode, evaluated on the live CPU inputs and only consumed
    // on the IDLE acceptance edge.
    logic                legal_d;
    logic [3:0]          be_d;
    logic [31:0]         wdata_d;

    always_comb begin
        legal_d = 1'b0;
        be_d    = 4'b0000;
        wdata_d = cpu_wdata;
        case (cpu_size)
            2'b00: begin
                legal_d = 1'b1;
                be_d    = 4'b0001 << cpu_addr[1:0];
                wdata_d = {4{cpu_wdata[7:0]}};
            end
            2'b01: begin
                legal_d = ~cpu_addr[0];
                be_d    = cpu_addr[1] ? 4'b1100 : 4'b0011;
                wdata_d = {2{cpu_wdata[15:0]}};
            end
            2'b10: begin
                legal_d = (cpu_addr[1:0] == 2'b00);
                be_d    = 4'b1111;
                wdata_d = cpu_wdata;
            end
            default: begin
                legal_d = 1'b0;
                be_d    = 4'b0000;
                wdata_d = cpu_wdata;
            end
        endcase
    end

    // Load extraction from the latched lane/size/sign of the access in flight.
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_d;

    always_comb begin
        case (lane_q)
            2'd1:    byte_sel = mem_rdata[15:8];
            2'd2:    byte_sel = mem_rdata[23:16];
            2'd3:    byte_sel = mem_rdata[31:24];
            default: byte_sel = mem_rdata[7:0];
        endcase
        half_sel = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (size_q)
            2'b00:   load_d = {{24{sign_q & byte_sel[7]}}, byte_sel};
            2'b01:   load_d = {{16{sign_q & half_sel[15]}}, half_sel};
            default: load_d = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            size_q      <= 2'b00;
            sign_q      <= 1'b0;
            lane_q      <= 2'b00;
            cpu_rdata_q <= 32'd0;
            cpu_ready_q <= 1'b0;
            cpu_err_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'd0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= 4'b0000;
        end else begin
            case (state_q)
                S_IDLE: begin
                    cpu_ready_q <= 1'b0;
                    mem_we_q    <= 1'b0;
                    if (cpu_req) begin
                        we_q      <= cpu_we;
                        size_q    <= cpu_size;
                        sign_q    <= cpu_sign;
                        lane_q    <= cpu_addr[1:0];
                        cpu_err_q <= ~legal_d;
                        if (legal_d) begin
                            state_q     <= S_ACCESS;
                            cnt_q       <= WAIT_L;
                            mem_addr_q  <= {cpu_addr[ADDR_W-1:2], 2'b00};
                            mem_be_q    <= be_d;
                            mem_wdata_q <= wdata_d;
                            // With no wait states the first ACCESS cycle is
                            // also the last, so the strobe goes up right away.
                            mem_we_q    <= cpu_we && (WAIT_L == 4'd0);
                        end else begin
                            // Illegal: skip the memory cycle entirely.
                            state_q     <= S_DONE;
                            cpu_ready_q <= 1'b1;
                            mem_be_q    <= 4'b0000;
                        end
                    end
                end
                S_ACCESS: begin
                    if (cnt_q == 4'd0) begin
                        state_q     <= S_DONE;
                        cpu_ready_q <= 1'b1;
                        mem_we_q    <= 1'b0;
                        mem_be_q    <= 4'b0000;
                        if (!we_q) begin
                            cpu_rdata_q <= load_d;
                        end
                    end else begin
                        cnt_q    <= cnt_q - 4'd1;
                        // Strobe is registered, so raise it one edge ahead of
                        // the cycle in which the counter reads zero.
                        mem_we_q <= we_q && (cnt_q == 4'd1);
                    end
                end
                S_DONE: begin
                    cpu_ready_q <= 1'b0;
                    state_q     <= S_IDLE;
                end
                default: begin
                    state_q     <= S_IDLE;
                    cpu_ready_q <= 1'b0;
                    mem_we_q    <= 1'b0;
                    mem_be_q    <= 4'b0000;
                end
            endcase
        end
    end

    assign cpu_rdata = cpu_rdata_q;
    assign cpu_ready = cpu_ready_q;
    assign cpu_err   = cpu_err_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;
    assign mem_be    = mem_be_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_access_ctrl
//
// Three controller instances (WAIT_CYCLES = 1, 0, 3) share one stimulus
// stream, each with its own small word memory. The driver pushes expected
// responses and expected memory writes into per-instance queues; a negedge
// monitor pops and compares whenever an instance raises cpu_ready or
// mem_we, and checks mem_addr/mem_be against the access in flight.
// ---------------------------------------------------------------------------
module tb_mem_access_ctrl;

    localparam int AW = 32;
    localparam int ND = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic          cpu_req   = 1'b0;
    logic          cpu_we    = 1'b0;
    logic [1:0]    cpu_size  = 2'b00;
    logic          cpu_sign  = 1'b0;
    logic [AW-1:0] cpu_addr  = '0;
    logic [31:0]   cpu_wdata = 32'd0;

    logic [31:0]   cpu_rdata [ND];
    logic          cpu_ready [ND];
    logic          cpu_err   [ND];
    logic [AW-1:0] mem_addr  [ND];
    logic [31:0]   mem_wdata [ND];
    logic [31:0]   mem_rdata [ND];
    logic          mem_we    [ND];
    logic [3:0]    mem_be    [ND];

    function automatic int wait_of(input int d);
        return (d == 0) ? 1 : ((d == 1) ? 0 : 3);
    endfunction

    for (genvar gi = 0; gi < ND; gi++) begin : g_dut
        logic [31:0] mem [64];

        mem_access_ctrl #(
            .ADDR_W     (AW),
            .WAIT_CYCLES((gi == 0) ? 1 : ((gi == 1) ? 0 : 3))
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .cpu_req  (cpu_req),
            .cpu_we   (cpu_we),
            .cpu_size (cpu_size),
            .cpu_sign (cpu_sign),
            .cpu_addr (cpu_addr),
            .cpu_wdata(cpu_wdata),
            .cpu_rdata(cpu_rdata[gi]),
            .cpu_ready(cpu_ready[gi]),
            .cpu_err  (cpu_err[gi]),
            .mem_addr (mem_addr[gi]),
            .mem_wdata(mem_wdata[gi]),
            .mem_we   (mem_we[gi]),
            .mem_be   (mem_be[gi]),
            .mem_rdata(mem_rdata[gi])
        );

        initial begin
            foreach (mem[i]) mem[i] = 32'd0;
        end

        assign mem_rdata[gi] = mem[mem_addr[gi][7:2]];

        always @(posedge clk) begin
            if (mem_we[gi]) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_be[gi][b]) mem[mem_addr[gi][7:2]][8*b +: 8] <= mem_wdata[gi][8*b +: 8];
                end
            end
        end
    end

    typedef struct {
        logic        legal;
        logic [31:0] rdata;
        logic [31:0] addr;
        logic [3:0]  be;
        int          base;
    } sb_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } wr_t;

    sb_t sbq [ND][$];
    wr_t wq  [ND][$];

    int cyc    = 0;
    int n_chk  = 0;
    int n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (rst) begin
            for (int d = 0; d < ND; d++) begin
                if (mem_be[d] != 4'b0000) begin
                    if (sbq[d].size() == 0) begin
                        chk($sformatf("d%0d stray_mem_be", d), {28'd0, mem_be[d]}, 32'd0);
                    end else begin
                        chk($sformatf("d%0d mem_addr", d), mem_addr[d], sbq[d][0].addr);
                        chk($sformatf("d%0d mem_be", d), {28'd0, mem_be[d]}, {28'd0, sbq[d][0].be});
                    end
                end
                if (mem_we[d]) begin
                    if (wq[d].size() == 0) begin
                        chk($sformatf("d%0d stray_mem_we", d), {31'd0, mem_we[d]}, 32'd0);
                    end else begin
                        wr_t w;
                        w = wq[d].pop_front();
                        chk($sformatf("d%0d wr_addr", d), mem_addr[d], w.addr);
                        chk($sformatf("d%0d wr_be", d), {28'd0, mem_be[d]}, {28'd0, w.be});
                        chk($sformatf("d%0d wr_data", d), mem_wdata[d], w.wdata);
                    end
                end
                if (cpu_ready[d]) begin
                    if (sbq[d].size() == 0) begin
                        chk($sformatf("d%0d stray_ready", d), {31'd0, cpu_ready[d]}, 32'd0);
                    end else begin
                        sb_t e;
                        int  exp_cyc;
                        e = sbq[d].pop_front();
                        exp_cyc = e.base + 1 + (e.legal ? wait_of(d) + 1 : 0);
                        chk($sformatf("d%0d cpu_rdata", d), cpu_rdata[d], e.rdata);
                        chk($sformatf("d%0d cpu_err", d), {31'd0, cpu_err[d]}, {31'd0, ~e.legal});
                        chk($sformatf("d%0d ready_cycle", d), 32'(cyc), 32'(exp_cyc));
                    end
                end
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while (n < 40 && !(sbq[0].size() == 0 && sbq[1].size() == 0 && sbq[2].size() == 0)) begin
            @(posedge clk);
            n++;
        end
        if (n >= 40) begin
            n_chk++;
            n_fail++;
            $display("FAIL timeout: responses still pending after %0d cycles, required 0 pending", n);
            for (int d = 0; d < ND; d++) begin
                sbq[d].delete();
                wq[d].delete();
            end
        end
    endtask

    // One access; be==0 marks an illegal request. Inputs are scrambled right
    // after the accept edge so the latched copy is what gets checked.
    task automatic access(input logic we, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic [3:0] be,
                          input logic [31:0] mwd);
        sb_t e;
        wr_t w;
        @(negedge clk);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_size  = sz;
        cpu_sign  = sg;
        cpu_addr  = a;
        cpu_wdata = wd;
        e.legal = (be != 4'b0000);
        e.rdata = exp_rd;
        e.addr  = {a[31:2], 2'b00};
        e.be    = be;
        e.base  = cyc;
        w.addr  = {a[31:2], 2'b00};
        w.wdata = mwd;
        w.be    = be;
        for (int d = 0; d < ND; d++) begin
            sbq[d].push_back(e);
            if (e.legal && we) wq[d].push_back(w);
        end
        $display("access we=%0b size=%0b sign=%0b addr=0x%08h wdata=0x%08h exp_rdata=0x%08h exp_be=%04b",
                 we, sz, sg, a, wd, exp_rd, be);
        @(posedge clk);
        #1;
        cpu_req   = 1'b0;
        cpu_we    = ~we;
        cpu_size  = ~sz;
        cpu_sign  = ~sg;
        cpu_addr  = ~a;
        cpu_wdata = ~wd;
        wait_idle();
    endtask

    task automatic check_reset_state(input string tag);
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("%s d%0d cpu_rdata", tag, d), cpu_rdata[d], 32'd0);
            chk($sformatf("%s d%0d cpu_ready", tag, d), {31'd0, cpu_ready[d]}, 32'd0);
            chk($sformatf("%s d%0d cpu_err", tag, d), {31'd0, cpu_err[d]}, 32'd0);
            chk($sformatf("%s d%0d mem_addr", tag, d), mem_addr[d], 32'd0);
            chk($sformatf("%s d%0d mem_wdata", tag, d), mem_wdata[d], 32'd0);
            chk($sformatf("%s d%0d mem_we", tag, d), {31'd0, mem_we[d]}, 32'd0);
            chk($sformatf("%s d%0d mem_be", tag, d), {28'd0, mem_be[d]}, 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        @(negedge clk);
        rst = 1'b1;

        // Reset mid-store: must drop mem_we without a clock edge.
        @(negedge clk);
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_size  = 2'b10;
        cpu_sign  = 1'b0;
        cpu_addr  = 32'h10;
        cpu_wdata = 32'h55555555;
        $display("access we=1 size=10 addr=0x00000010 wdata=0x55555555 aborted by reset");
        @(posedge clk);
        #2;
        cpu_req = 1'b0;
        rst     = 1'b0;
        #1;
        check_reset_state("abort");
        @(negedge clk);
        rst = 1'b1;

        //      we    size   sg    addr           wdata          exp_rdata      be     mem_wdata
        access(1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'hDEADBEEF, 32'h0000_0000, 4'hF, 32'hDEADBEEF);
        access(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0,        32'hDEADBEEF, 4'hF, 32'h0);
        access(1'b1, 2'b00, 1'b0, 32'h0000_0013, 32'h123456A5, 32'hDEADBEEF, 4'h8, 32'hA5A5A5A5);
        access(1'b0, 2'b00, 1'b1, 32'h0000_0013, 32'h0,        32'hFFFFFFA5, 4'h8, 32'h0);
        access(1'b0, 2'b00, 1'b0, 32'h0000_0013, 32'h0,        32'h000000A5, 4'h8, 32'h0);
        access(1'b1, 2'b10, 1'b0, 32'h0000_0020, 32'h80017F02, 32'h000000A5, 4'hF, 32'h80017F02);
        access(1'b0, 2'b01, 1'b1, 32'h0000_0022, 32'h0,        32'hFFFF8001, 4'hC, 32'h0);
        access(1'b0, 2'b01, 1'b0, 32'h0000_0020, 32'h0,        32'h00007F02, 4'h3, 32'h0);
        // Illegal: misaligned half, misaligned word, size 11
        access(1'b0, 2'b01, 1'b1, 32'h0000_0021, 32'h0,        32'h00007F02, 4'h0, 32'h0);
        access(1'b1, 2'b10, 1'b0, 32'h0000_0012, 32'hCAFEF00D, 32'h00007F02, 4'h0, 32'h0);
        access(1'b0, 2'b11, 1'b1, 32'h0000_0010, 32'h0,        32'h00007F02, 4'h0, 32'h0);
        access(1'b1, 2'b01, 1'b0, 32'h0000_0012, 32'h1234C0DE, 32'h00007F02, 4'hC, 32'hC0DEC0DE);
        access(1'b0, 2'b01, 1'b1, 32'h0000_0012, 32'h0,        32'hFFFFC0DE, 4'hC, 32'h0);
        access(1'b0, 2'b00, 1'b0, 32'h0000_0011, 32'h0,        32'h000000BE, 4'h2, 32'h0);
        access(1'b0, 2'b00, 1'b1, 32'h0000_0010, 32'h0,        32'hFFFFFFEF, 4'h1, 32'h0);
        access(1'b0, 2'b10, 1'b1, 32'h0000_0020, 32'h0,        32'h80017F02, 4'hF, 32'h0);
        // Top of the address space is legal
        access(1'b1, 2'b10, 1'b0, 32'hFFFF_FFFC, 32'h13579BDF, 32'h80017F02, 4'hF, 32'h13579BDF);
        access(1'b0, 2'b10, 1'b0, 32'hFFFF_FFFC, 32'h0,        32'h13579BDF, 4'hF, 32'h0);
        access(1'b1, 2'b00, 1'b0, 32'h0000_0021, 32'hFFFFFF7E, 32'h13579BDF, 4'h2, 32'h7E7E7E7E);
        access(1'b0, 2'b00, 1'b1, 32'h0000_0021, 32'h0,        32'h0000007E, 4'h2, 32'h0);
        access(1'b0, 2'b10, 1'b0, 32'h0000_0020, 32'h0,        32'h80017E02, 4'hF, 32'h0);

        repeat (3) @(posedge clk);
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("d%0d writes_outstanding", d), 32'(wq[d].size()), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
